// File: rtl/hint_unpack_ctrl.sv
// Sequencer around the ML-DSA hint-bit unpack engine: collects the hint section,
// launches and supervises the engine, streams K*256 hint bits as 32-bit words.
module hint_unpack_ctrl #(
  parameter int K       = 8,
  parameter int OMEGA   = 75,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic [0:(OMEGA+K)*8-1]   unpack_y,
  output logic                     unpack_start,
  input  logic                     unpack_done,
  input  logic                     unpack_valid,
  output logic [$clog2(K)-1:0]     unpack_row_sel,
  input  logic [255:0]             unpack_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic                     status_valid,
  output logic [1:0]               status_code,
  output logic                     busy
);
  localparam int N  = OMEGA + K;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(K);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_STREAM = 3'd5;
  localparam logic [2:0] S_REPORT = 3'd6;

  localparam logic [1:0] CODE_OK  = 2'd0;
  localparam logic [1:0] CODE_LEN = 2'd1;
  localparam logic [1:0] CODE_MAL = 2'd2;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [RW-1:0] row_reg, row_next;
  logic [2:0]    word_reg, word_next;
  logic [1:0]    code_reg, code_next;
  logic [0:N*8-1] buf_reg;
  logic [31:0]   words [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign words[gi] = unpack_row[32*gi +: 32];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    timer_next = timer_reg;
    row_next   = row_reg;
    word_next  = word_reg;
    code_next  = code_reg;
    case (state_reg)
      S_IDLE: if (cmd_start) begin
        cnt_next   = '0;
        code_next  = CODE_OK;
        state_next = S_LOAD;
      end
      S_LOAD: if (in_valid) begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(N - 1)) begin
          if (in_last) begin
            state_next = S_START;
          end else begin
            code_next  = CODE_LEN;
            state_next = S_DRAIN;
          end
        end else if (in_last) begin
          code_next  = CODE_LEN;
          state_next = S_REPORT;
        end
      end
      S_DRAIN: if (in_valid && in_last) state_next = S_REPORT;
      S_START: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over the timeout on the same cycle
        if (unpack_done) begin
          if (unpack_valid) begin
            row_next   = '0;
            word_next  = '0;
            state_next = S_STREAM;
          end else begin
            code_next  = CODE_MAL;
            state_next = S_REPORT;
          end
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          code_next  = CODE_MAL;
          state_next = S_REPORT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_STREAM: if (out_ready) begin
        if (word_reg == 3'd7) begin
          word_next = '0;
          if (row_reg == RW'(K - 1)) begin
            code_next  = CODE_OK;
            state_next = S_REPORT;
          end else begin
            row_next = row_reg + 1'b1;
          end
        end else begin
          word_next = word_reg + 1'b1;
        end
      end
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      timer_reg <= '0;
      row_reg   <= '0;
      word_reg  <= '0;
      code_reg  <= CODE_OK;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      timer_reg <= timer_next;
      row_reg   <= row_next;
      word_reg  <= word_next;
      code_reg  <= code_next;
    end
  end

  // Ascending slice: in_data[7] lands on bit 8*slot, no reordering of bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_reg <= '0;
    end else if (state_reg == S_LOAD && in_valid) begin
      buf_reg[8*cnt_reg +: 8] <= in_data;
    end
  end

  assign unpack_y       = buf_reg;
  assign in_ready       = (state_reg == S_LOAD) || (state_reg == S_DRAIN);
  assign unpack_start   = (state_reg == S_START);
  assign out_valid      = (state_reg == S_STREAM);
  assign out_data       = out_valid ? words[word_reg] : '0;
  assign out_last       = out_valid && (row_reg == RW'(K - 1)) && (word_reg == 3'd7);
  assign unpack_row_sel = row_reg;
  assign status_valid   = (state_reg == S_REPORT);
  assign status_code    = code_reg;
  assign busy           = (state_reg != S_IDLE);
endmodule

// File: tb/tb_hint_unpack_ctrl.sv
// Bench for hint_unpack_ctrl: behavioural unpack engine plus directed and random
// signatures, checked against hint masks generated by the bench itself.
module tb_hint_unpack_ctrl;
  localparam int K       = 8;
  localparam int OMEGA   = 75;
  localparam int N       = OMEGA + K;
  localparam int TIMEOUT = 1023;
  localparam int NW      = 8 * K;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_start = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_data = 8'h00;
  logic           in_last = 1'b0;
  logic [0:N*8-1] unpack_y;
  logic           unpack_start;
  logic           unpack_done;
  logic           unpack_valid;
  logic [2:0]     unpack_row_sel;
  logic [255:0]   unpack_row;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [31:0]    out_data;
  logic           out_last;
  logic           status_valid;
  logic [1:0]     status_code;
  logic           busy;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cnt = 0;
  logic [7:0]   sig_q [$];
  logic [255:0] exp_h [K];
  int           eng_lat = 4;
  bit           eng_hang = 1'b0;
  logic [7:0]   eng_bytes [N] = '{default: 8'h00};
  int           eng_cnt;
  bit           eng_busy;

  hint_unpack_ctrl #(.K(K), .OMEGA(OMEGA), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .unpack_y(unpack_y), .unpack_start(unpack_start),
    .unpack_done(unpack_done), .unpack_valid(unpack_valid),
    .unpack_row_sel(unpack_row_sel), .unpack_row(unpack_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .status_valid(status_valid), .status_code(status_code), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (unpack_start) start_cnt <= start_cnt + 1;

  // HintBitUnpack rules: cumulative row ends, strictly ascending indices, zero padding
  function automatic bit well_formed(input logic [7:0] b [N]);
    int idx = 0;
    for (int r = 0; r < K; r++) begin
      int e = int'(b[OMEGA + r]);
      if (e < idx || e > OMEGA) return 1'b0;
      for (int j = idx + 1; j < e; j++) if (b[j-1] >= b[j]) return 1'b0;
      idx = e;
    end
    for (int j = idx; j < OMEGA; j++) if (b[j] != 8'h00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [255:0] row_of(input logic [7:0] b [N], input int r);
    logic [255:0] h = '0;
    int lo, hi;
    lo = (r == 0) ? 0 : int'(b[OMEGA + r - 1]);
    hi = int'(b[OMEGA + r]);
    if (hi <= OMEGA && lo <= hi) for (int j = lo; j < hi; j++) h[b[j]] = 1'b1;
    return h;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      unpack_done <= 1'b0; unpack_valid <= 1'b0; eng_busy <= 1'b0; eng_cnt <= 0;
    end else if (unpack_start) begin
      for (int i = 0; i < N; i++) eng_bytes[i] <= unpack_y[8*i +: 8];
      unpack_done <= 1'b0; unpack_valid <= 1'b0; eng_busy <= 1'b1; eng_cnt <= 0;
    end else if (eng_busy && !eng_hang) begin
      if (eng_cnt >= eng_lat) begin
        unpack_done <= 1'b1; unpack_valid <= well_formed(eng_bytes); eng_busy <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  always_comb unpack_row = row_of(eng_bytes, int'(unpack_row_sel));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic [0:N*8-1] obs, input logic [0:N*8-1] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_masks();
    int tot = 0;
    for (int r = 0; r < K; r++) begin
      exp_h[r] = '0;
      for (int bi = 0; bi < 256; bi++)
        if (tot < OMEGA && $urandom_range(0, 39) == 0) begin exp_h[r][bi] = 1'b1; tot++; end
    end
  endtask

  task automatic build_sig();
    int pos = 0;
    sig_q = {};
    for (int i = 0; i < N; i++) sig_q.push_back(8'h00);
    for (int r = 0; r < K; r++) begin
      for (int bi = 0; bi < 256; bi++) if (exp_h[r][bi]) begin sig_q[pos] = 8'(bi); pos++; end
      sig_q[OMEGA + r] = 8'(pos);
    end
  endtask

  task automatic run_sig(input string name, input int exp_code, input bit stall,
                         input bit tmo, input bit abort);
    int idx = 0, k = 0, guard = 0, s0, t_start = 0;
    bit accept, held_v = 1'b0, finished = 1'b0, first_seen = 1'b0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    logic [255:0] row_bits;
    logic [7:0] b;
    logic [0:N*8-1] exp_y;
    for (int i = 0; i < N; i++) begin
      b = (i < sig_q.size()) ? sig_q[i] : 8'h00;
      for (int j = 0; j < 8; j++) exp_y[8*i + j] = b[7-j];
    end
    s0 = start_cnt;
    cmd_start = 1'b1; @(posedge clk); #1; cmd_start = 1'b0;
    chk($sformatf("%s_busy", name), 32'(busy), 32'd1);
    while (idx < sig_q.size() && guard < 4*N + 100) begin
      in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = sig_q[idx];
      in_last  = (idx == sig_q.size() - 1);
      accept   = in_valid && in_ready;
      @(posedge clk); #1;
      if (accept) idx++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk($sformatf("%s_bytes_taken", name), idx, sig_q.size());
    if (exp_code == 1) begin
      chk($sformatf("%s_status_valid", name), 32'(status_valid), 32'd1);
      chk($sformatf("%s_status_code", name), 32'(status_code), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("%s_idle", name), 32'(busy), 32'd0);
      chk($sformatf("%s_no_start", name), start_cnt - s0, 32'd0);
      return;
    end
    chk($sformatf("%s_start_pulse", name), 32'(unpack_start), 32'd1);
    chk_y($sformatf("%s_unpack_y", name), unpack_y, exp_y);
    t_start = cyc;
    for (int c = 0; c < 3000 && !finished; c++) begin
      if (abort && k == 20) begin
        rst = 1'b1; #1;
        chk($sformatf("%s_rst_ctrl", name),
            32'({in_ready, unpack_start, out_valid, out_last, status_valid, busy, status_code, unpack_row_sel}), 32'd0);
        chk($sformatf("%s_rst_data", name), out_data, 32'd0);
        chk_y($sformatf("%s_rst_y", name), unpack_y, '0);
        @(posedge clk); #1;
        chk($sformatf("%s_rst_no_status", name), 32'({status_valid, busy}), 32'd0);
        rst = 1'b0;
        finished = 1'b1;
      end else begin
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (held_v) begin
          chk($sformatf("%s_stall_valid", name), 32'(out_valid), 32'd1);
          chk($sformatf("%s_stall_data", name), out_data, held_d);
          chk($sformatf("%s_stall_last", name), 32'(out_last), 32'(held_l));
        end
        held_v = 1'b0;
        if (out_valid) begin
          if (!first_seen) begin
            chk($sformatf("%s_first_valid_lat", name), cyc - t_start, eng_lat + 3);
            first_seen = 1'b1;
          end
          if (out_ready) begin
            row_bits = exp_h[k / 8];
            chk($sformatf("%s_word%0d", name, k), out_data, row_bits[32*(k % 8) +: 32]);
            chk($sformatf("%s_last%0d", name, k), 32'(out_last), 32'(k == NW - 1));
            k++;
          end else begin
            held_d = out_data; held_l = out_last; held_v = 1'b1;
          end
        end
        if (status_valid) begin
          chk($sformatf("%s_status_code", name), 32'(status_code), 32'(exp_code));
          chk($sformatf("%s_word_count", name), k, (exp_code == 0) ? NW : 0);
          chk($sformatf("%s_one_start", name), start_cnt - s0, 32'd1);
          if (tmo) chk($sformatf("%s_timeout_cycles", name), cyc - t_start, TIMEOUT + 1);
          finished = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk($sformatf("%s_finished", name), 32'(finished), 32'd1);
  endtask

  task automatic directed_masks();
    for (int r = 0; r < K; r++) exp_h[r] = '0;
    exp_h[0][5] = 1'b1; exp_h[0][200] = 1'b1;
    exp_h[1][0] = 1'b1; exp_h[1][31] = 1'b1; exp_h[1][255] = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({in_ready, unpack_start, out_valid, out_last, status_valid, busy}), 32'd0);
    chk("rst_code", 32'(status_code), 32'd0);
    chk("rst_row_sel", 32'(unpack_row_sel), 32'd0);
    chk_y("rst_y", unpack_y, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    directed_masks(); build_sig();
    chk("directed_row0_word0", exp_h[0][31:0], 32'h0000_0020);
    eng_lat = 6;
    run_sig("directed", 0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("directed_code_held", 32'(status_code), 32'd0);

    directed_masks(); build_sig();
    run_sig("directed_stall", 0, 1'b1, 1'b0, 1'b0);

    rand_masks(); build_sig();
    while (sig_q.size() > 41) void'(sig_q.pop_back());
    run_sig("short", 1, 1'b0, 1'b0, 1'b0);

    rand_masks(); build_sig();
    repeat (7) sig_q.push_back(8'($urandom_range(0, 255)));
    run_sig("drain", 1, 1'b1, 1'b0, 1'b0);

    directed_masks(); build_sig();
    b_swap: begin
      logic [7:0] t = sig_q[2];
      sig_q[2] = sig_q[3]; sig_q[3] = t;
    end
    run_sig("malformed", 2, 1'b0, 1'b0, 1'b0);

    eng_hang = 1'b1;
    rand_masks(); build_sig();
    run_sig("timeout", 2, 1'b0, 1'b1, 1'b0);
    eng_hang = 1'b0;

    for (int t = 0; t < 4; t++) begin
      rand_masks(); build_sig();
      eng_lat = $urandom_range(1, 20);
      run_sig($sformatf("rand%0d", t), 0, t[0], 1'b0, 1'b0);
    end

    rand_masks(); build_sig();
    run_sig("abort", 0, 1'b1, 1'b0, 1'b1);
    rand_masks(); build_sig();
    run_sig("post_abort", 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
